ir_send: RTL and testbench
==========================

IR_SEND -- requirements
Module: ir_send

Interface
REQ-001 Parameters (name, default, meaning), all durations in clk cycles (1 us each):
- LEAD_L, 9000, leader low time
- LEAD_H, 4500, leader high time
- BIT_L, 560, mark (low) time per bit and for the stop mark
- ZERO_H, 560, space (high) time for a 0 bit
- ONE_H, 1690, space (high) time for a 1 bit
- GAP_H, 40000, minimum idle high time after the stop mark before busy falls
- CARR_HALF, 13, half-period of the ~38 kHz carrier
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single 1 MHz clock; all logic is on the rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, frame request, sampled on each rising edge
- addr, in, 8, NEC address byte
- code, in, 8, NEC command byte
- ir, out, 1, demodulated-level line: idle high, mark low
- ir_carrier, out, 1, modulated line: carrier while ir is low, 0 otherwise
- busy, out, 1, frame or gap in progress
- done, out, 1, one-cycle pulse at the end of the stop mark

Function
REQ-003 The FSM states are IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, STOP and GAP.
REQ-004 In IDLE with start=1 at edge k: latch frame = {~code, code, ~addr, addr}; set busy=1, ir=0 and enter LEAD_L, all effective at edge k.
REQ-005 start is ignored while busy=1; addr and code are only sampled at acceptance.
REQ-006 Each segment holds ir constant for exactly its parameter count of cycles, then transitions on the next edge:
- LEAD_L(0) -> LEAD_H(1)
- LEAD_H -> BIT_L(0)
- BIT_L -> BIT_H(1)
- BIT_H -> BIT_L for the next bit, or -> STOP(0) after bit 31
- STOP -> GAP(1)
- GAP -> IDLE
REQ-007 Bits are sent frame[0] first through frame[31], i.e. LSB-first: addr, ~addr, code, ~code. The BIT_H length is ONE_H when the current bit is 1 and ZERO_H when it is 0.
REQ-008 A 16-bit down- or up-counter times every segment; the counter reloads on each state entry; there is no wrap-around within any segment.
REQ-009 A 5-bit bit index starts at 0 on entry to LEAD_H and increments on each BIT_H exit; the decision to move to STOP is made on index 31.
REQ-010 done=1 for exactly one cycle, on the edge where STOP -> GAP (ir rises).
REQ-011 busy falls on the GAP -> IDLE edge. A start in that same cycle is not accepted; it is accepted on the next edge if still high.
REQ-012 ir_carrier:
- is 0 whenever ir=1
- restarts phase high at every ir falling edge
- toggles every CARR_HALF cycles while ir=0

Reset
REQ-013 rst_n=0 forces, immediately and asynchronously: state=IDLE, ir=1, ir_carrier=0, busy=0, done=0, and counter, bit index and latched frame cleared.
REQ-014 Reset asserted mid-frame aborts the frame with no done pulse. After release, the block waits in IDLE for a new start.

Verification
REQ-015 addr=0x00, code=0x00, single start pulse -> ir low 9000 cycles, high 4500, then:
- 8 bits of 560L/560H
- 8 bits of 560L/1690H
- 8 bits of 560L/560H
- 8 bits of 560L/1690H
- stop 560L
- done pulse; busy stays high 40000 more cycles
- total ir activity 67980 cycles
REQ-016 addr=0x01, code=0x45 -> first bit space is 1690, second is 560. Decoding the spaces LSB-first yields bytes 0x01, 0xFE, 0x45, 0xBA.
REQ-017 start held high continuously, with addr or code changed mid-frame -> the frame content is unchanged. A second frame begins on the edge after busy falls.
REQ-018 Carrier check during the leader -> ir_carrier is 13 cycles high, 13 low, repeating, starting high on the ir falling edge. ir_carrier=0 throughout every high segment.
REQ-019 Assert rst_n=0 during bit 10 -> ir=1 and busy=0 without waiting for a clock edge, and no done pulse. After release, a new start yields a complete correct frame.

Source files
------------

// File: rtl/ir_send.sv
// ============================================================================
// Module   : ir_send
// Brief    : NEC infrared frame transmitter with demodulated and carrier outputs
// Revision : 1.0
// ============================================================================
`default_nettype none

module ir_send #(
    parameter int LEAD_L    = 9000,
    parameter int LEAD_H    = 4500,
    parameter int BIT_L     = 560,
    parameter int ZERO_H    = 560,
    parameter int ONE_H     = 1690,
    parameter int GAP_H     = 40000,
    parameter int CARR_HALF = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] code,
    output logic       ir,
    output logic       ir_carrier,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LEAD_L = 3'd1;
    localparam logic [2:0] c_LEAD_H = 3'd2;
    localparam logic [2:0] c_BIT_L  = 3'd3;
    localparam logic [2:0] c_BIT_H  = 3'd4;
    localparam logic [2:0] c_STOP   = 3'd5;
    localparam logic [2:0] c_GAP    = 3'd6;

    // Counter reload values are length-1 so each segment lasts exactly its length.
    localparam logic [15:0] c_LD_LEAD_L = 16'(LEAD_L - 1);
    localparam logic [15:0] c_LD_LEAD_H = 16'(LEAD_H - 1);
    localparam logic [15:0] c_LD_BIT_L  = 16'(BIT_L - 1);
    localparam logic [15:0] c_LD_ZERO_H = 16'(ZERO_H - 1);
    localparam logic [15:0] c_LD_ONE_H  = 16'(ONE_H - 1);
    localparam logic [15:0] c_LD_GAP_H  = 16'(GAP_H - 1);
    localparam logic [15:0] c_LD_CARR   = 16'(CARR_HALF - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [4:0]  r_idx;
    logic [31:0] r_frame;
    logic        r_ir;
    logic        r_carr;
    logic [15:0] r_ccnt;
    logic        r_busy;
    logic        r_done;

    logic [2:0]  w_state_nx;
    logic [15:0] w_cnt_nx;
    logic [4:0]  w_idx_nx;
    logic [31:0] w_frame_nx;
    logic        w_ir_nx;
    logic        w_busy_nx;
    logic        w_done_nx;
    logic        w_seg_end;

    assign w_seg_end = (r_cnt == 16'd0);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = w_seg_end ? r_cnt : r_cnt - 16'd1;
        w_idx_nx   = r_idx;
        w_frame_nx = r_frame;
        w_ir_nx    = r_ir;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_frame_nx = {~code, code, ~addr, addr};
                    w_busy_nx  = 1'b1;
                    w_ir_nx    = 1'b0;
                    w_cnt_nx   = c_LD_LEAD_L;
                    w_state_nx = c_LEAD_L;
                end
            end
            c_LEAD_L: begin
                if (w_seg_end) begin
                    w_ir_nx    = 1'b1;
                    w_idx_nx   = 5'd0;
                    w_cnt_nx   = c_LD_LEAD_H;
                    w_state_nx = c_LEAD_H;
                end
            end
            c_LEAD_H: begin
                if (w_seg_end) begin
                    w_ir_nx    = 1'b0;
                    w_cnt_nx   = c_LD_BIT_L;
                    w_state_nx = c_BIT_L;
                end
            end
            c_BIT_L: begin
                if (w_seg_end) begin
                    w_ir_nx    = 1'b1;
                    w_cnt_nx   = r_frame[r_idx] ? c_LD_ONE_H : c_LD_ZERO_H;
                    w_state_nx = c_BIT_H;
                end
            end
            c_BIT_H: begin
                if (w_seg_end) begin
                    w_ir_nx    = 1'b0;
                    w_cnt_nx   = c_LD_BIT_L;
                    w_idx_nx   = r_idx + 5'd1;
                    w_state_nx = (r_idx == 5'd31) ? c_STOP : c_BIT_L;
                end
            end
            c_STOP: begin
                if (w_seg_end) begin
                    w_ir_nx    = 1'b1;
                    w_done_nx  = 1'b1;
                    w_cnt_nx   = c_LD_GAP_H;
                    w_state_nx = c_GAP;
                end
            end
            c_GAP: begin
                if (w_seg_end) begin
                    w_busy_nx  = 1'b0;
                    w_cnt_nx   = 16'd0;
                    w_state_nx = c_IDLE;
                end
            end
            default: begin
                w_ir_nx    = 1'b1;
                w_busy_nx  = 1'b0;
                w_cnt_nx   = 16'd0;
                w_state_nx = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 5'd0;
            r_frame <= 32'd0;
            r_ir    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_frame <= w_frame_nx;
            r_ir    <= w_ir_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    // Carrier phase restarts high on every mark so each mark begins with a full half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carr <= 1'b0;
            r_ccnt <= 16'd0;
        end else if (w_ir_nx) begin
            r_carr <= 1'b0;
            r_ccnt <= 16'd0;
        end else if (r_ir) begin
            r_carr <= 1'b1;
            r_ccnt <= c_LD_CARR;
        end else if (r_ccnt == 16'd0) begin
            r_carr <= ~r_carr;
            r_ccnt <= c_LD_CARR;
        end else begin
            r_ccnt <= r_ccnt - 16'd1;
        end
    end

    assign ir         = r_ir;
    assign ir_carrier = r_carr;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ir_send.sv
// ============================================================================
// Module   : tb_ir_send
// Brief    : Randomized self-checking bench for ir_send against a waveform model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ir_send;

    localparam int P_LEAD_L = 20;
    localparam int P_LEAD_H = 10;
    localparam int P_BIT_L  = 3;
    localparam int P_ZERO_H = 2;
    localparam int P_ONE_H  = 5;
    localparam int P_GAP_H  = 12;
    localparam int P_CARR   = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] addr  = 8'd0;
    logic [7:0] code  = 8'd0;
    logic       ir;
    logic       ir_carrier;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected ir level for every cycle after the acceptance edge, built from the frame rules.
    logic exp_ir[$];
    int   done_idx;
    int   bit_start[32];

    always #5 clk = ~clk;

    ir_send #(
        .LEAD_L   (P_LEAD_L),
        .LEAD_H   (P_LEAD_H),
        .BIT_L    (P_BIT_L),
        .ZERO_H   (P_ZERO_H),
        .ONE_H    (P_ONE_H),
        .GAP_H    (P_GAP_H),
        .CARR_HALF(P_CARR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .addr      (addr),
        .code      (code),
        .ir        (ir),
        .ir_carrier(ir_carrier),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build(input logic [7:0] a, input logic [7:0] c);
        logic [31:0] f;
        f = {~c, c, ~a, a};
        exp_ir.delete();
        repeat (P_LEAD_L) exp_ir.push_back(1'b0);
        repeat (P_LEAD_H) exp_ir.push_back(1'b1);
        for (int i = 0; i < 32; i++) begin
            bit_start[i] = exp_ir.size();
            repeat (P_BIT_L) exp_ir.push_back(1'b0);
            repeat (f[i] ? P_ONE_H : P_ZERO_H) exp_ir.push_back(1'b1);
        end
        repeat (P_BIT_L) exp_ir.push_back(1'b0);
        done_idx = exp_ir.size();
        repeat (P_GAP_H) exp_ir.push_back(1'b1);
    endfunction

    // Called at a negedge; the following rising edge accepts the frame.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] c,
                             input bit hold, input int abort_bit);
        logic [31:0] fexp;
        logic [31:0] dec;
        logic        prev;
        logic        ec;
        int          len;
        int          p;
        int          hi_run;
        int          falls;
        start = 1'b1;
        addr  = a;
        code  = c;
        build(a, c);
        fexp = {~c, c, ~a, a};
        @(negedge clk);
        if (!hold) start = 1'b0;
        len = exp_ir.size();
        prev = 1'b1; p = 0; hi_run = 0; falls = 0; dec = 32'd0;
        for (int j = 0; j < len; j++) begin
            if (abort_bit >= 0 && j == bit_start[abort_bit]) begin
                #2 rst_n = 1'b0;
                #1 check("rst_async", {28'd0, ir, ir_carrier, busy, done}, 32'b1000);
                return;
            end
            if (j == len / 2) begin
                addr = 8'($urandom);
                code = 8'($urandom);
            end
            if (!exp_ir[j]) p = (j == 0 || exp_ir[j-1]) ? 0 : p + 1;
            ec = !exp_ir[j] && ((p / P_CARR) % 2 == 0);
            check("frame", {28'd0, ir, ir_carrier, busy, done},
                  {28'd0, exp_ir[j], ec, 1'b1, (j == done_idx)});
            if (prev && !ir) begin
                if (falls >= 2 && falls <= 33)
                    dec[falls-2] = (hi_run > (P_ZERO_H + P_ONE_H) / 2);
                falls++;
                hi_run = 0;
            end
            if (ir) hi_run++;
            prev = ir;
            @(negedge clk);
        end
        check("idle_after", {28'd0, ir, ir_carrier, busy, done}, 32'b1000);
        check("decode", dec, fexp);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check("reset_state", {28'd0, ir, ir_carrier, busy, done}, 32'b1000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", {28'd0, ir, ir_carrier, busy, done}, 32'b1000);

        run_frame(8'h00, 8'h00, 1'b0, -1);
        run_frame(8'h01, 8'h45, 1'b0, -1);
        for (int k = 0; k < 3; k++)
            run_frame(8'($urandom), 8'($urandom), 1'b0, -1);

        // Start held high: back-to-back frames, second accepted right after busy falls.
        run_frame(8'($urandom), 8'($urandom), 1'b1, -1);
        run_frame(8'($urandom), 8'($urandom), 1'b1, -1);
        start = 1'b0;
        @(negedge clk);

        run_frame(8'($urandom), 8'($urandom), 1'b0, 10);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold", {28'd0, ir, ir_carrier, busy, done}, 32'b1000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {28'd0, ir, ir_carrier, busy, done}, 32'b1000);
        run_frame(8'($urandom), 8'($urandom), 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
